// File: rtl/lcd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_arb_pkg
// Description : Shared constants and FSM encoding for the LCD character-buffer
//               write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_arb_pkg;

  localparam int NREQ   = 4;   // requesters sharing the buffer write port
  localparam int LW     = 3;   // length field width (beats = len + 1)
  localparam int ADDR_W = 5;   // 32 character cells, two lines of 16
  localparam int DATA_W = 8;   // one character byte per cell

  localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns a one-hot winner
//               starting the search just after the previous winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic            valid_o
);

  logic [IW-1:0] w_cand;

  // Walk (last+1 .. last+NREQ) mod NREQ and grant the first active request.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(last_i) + k) % NREQ);
      if (!valid_o && req_i[w_cand]) begin
        win_o[w_cand] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_arbiter
// Description : Round-robin arbiter granting multi-beat write bursts from
//               several requesters onto a single LCD character-buffer port.
// Revision    : 1.0 - initial release
// ============================================================================
import lcd_arb_pkg::*;

module lcd_write_arbiter #(
  parameter int NREQ = lcd_arb_pkg::NREQ,
  parameter int LW   = lcd_arb_pkg::LW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*5-1:0]    addr_i,
  input  logic [NREQ*LW-1:0]   len_i,
  input  logic [NREQ*8-1:0]    data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [LW-1:0]        beat_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 w_o,
  output logic [4:0]           wadd_o,
  output logic [7:0]           din_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic [LW-1:0]       beat_q;
  logic [NREQ-1:0]     done_q;
  logic                w_q;
  logic [ADDR_W-1:0]   wadd_q;
  logic [DATA_W-1:0]   din_q;
  logic [IW-1:0]       last_q;   // previous winner, rotates priority
  logic [IW-1:0]       win_q;    // winner of the transfer in flight
  logic [ADDR_W-1:0]   base_q;   // latched start address
  logic [LW-1:0]       lastb_q;  // latched final beat index

  logic [NREQ-1:0]     w_pick_oh;
  logic                w_pick_vld;
  logic [IW-1:0]       w_pick_idx;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [LW-1:0]       w_len_sel;
  logic [DATA_W-1:0]   w_data_sel;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .win_o   (w_pick_oh),
    .valid_o (w_pick_vld)
  );

  // Steer the picked requester's addr/len and the granted requester's data byte.
  always_comb begin
    w_pick_idx = '0;
    w_addr_sel = '0;
    w_len_sel  = '0;
    w_data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_oh[i]) begin
        w_pick_idx = IW'(i);
        w_addr_sel = addr_i[i*ADDR_W +: ADDR_W];
        w_len_sel  = len_i[i*LW +: LW];
      end
      if (gnt_q[i]) begin
        w_data_sel = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration / burst FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      beat_q  <= '0;
      done_q  <= '0;
      w_q     <= 1'b0;
      wadd_q  <= '0;
      din_q   <= BLANK_CHAR;
      last_q  <= IW'(NREQ - 1);
      win_q   <= '0;
      base_q  <= '0;
      lastb_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          w_q <= 1'b0;
          if (w_pick_vld) begin
            state_q <= ST_XFER;
            gnt_q   <= w_pick_oh;
            win_q   <= w_pick_idx;
            base_q  <= w_addr_sel;
            lastb_q <= w_len_sel;
            beat_q  <= '0;
          end
        end
        ST_XFER: begin
          // The write lags the grant beat by one cycle; address wraps mod 32.
          w_q    <= 1'b1;
          wadd_q <= base_q + ADDR_W'(beat_q);
          din_q  <= w_data_sel;
          if (beat_q == lastb_q) begin
            state_q <= ST_DONE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_DONE: begin
          w_q     <= 1'b0;
          last_q  <= win_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          w_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign beat_o = beat_q;
  assign done_o = done_q;
  assign w_o    = w_q;
  assign wadd_o = wadd_q;
  assign din_o  = din_q;

endmodule
`default_nettype wire
